// File: rtl/boreal_vec_seq_if.sv
// Signal bundle between the boreal vector sequencer and its environment: command
// queue, operand buffer, result consumer and the lane array.
interface boreal_vec_seq_if #(
   parameter int NUM_LANES = 4,
   parameter int LEN_W     = 16
);
   // A transfer on cmd/in/res happens on a rising edge where valid and ready are both
   // high; the source holds its payload stable while valid is high and ready is low.
   logic                      cmd_valid;
   logic                      cmd_ready;
   logic [LEN_W-1:0]          cmd_len;
   logic                      cmd_do_scale;
   logic                      cmd_do_clamp;
   logic [15:0]               cfg_scale;
   logic [15:0]               cfg_zero_pt;
   logic [31:0]               cfg_clamp_min;
   logic [31:0]               cfg_clamp_max;

   logic                      in_valid;
   logic                      in_ready;
   logic [8*NUM_LANES-1:0]    in_a;
   logic [8*NUM_LANES-1:0]    in_b;

   logic                      lane_en;
   logic [2:0]                lane_op;
   logic [8*NUM_LANES-1:0]    lane_a;
   logic [8*NUM_LANES-1:0]    lane_b;
   logic [15:0]               lane_scale;
   logic [15:0]               lane_zero_pt;
   logic [31:0]               lane_clamp_min;
   logic [31:0]               lane_clamp_max;
   logic [32*NUM_LANES-1:0]   lane_acc;
   logic [NUM_LANES-1:0]      lane_done;

   logic                      res_valid;
   logic                      res_ready;
   logic [32*NUM_LANES-1:0]   res_data;

   logic                      busy;
   logic                      err;
   logic [2:0]                dbg_state;

   // master: environment (command source, operand source, lanes, result sink)
   modport master (
      output cmd_valid, cmd_len, cmd_do_scale, cmd_do_clamp,
             cfg_scale, cfg_zero_pt, cfg_clamp_min, cfg_clamp_max,
             in_valid, in_a, in_b, lane_acc, lane_done, res_ready,
      input  cmd_ready, in_ready, lane_en, lane_op, lane_a, lane_b,
             lane_scale, lane_zero_pt, lane_clamp_min, lane_clamp_max,
             res_valid, res_data, busy, err, dbg_state
   );

   modport slave (
      input  cmd_valid, cmd_len, cmd_do_scale, cmd_do_clamp,
             cfg_scale, cfg_zero_pt, cfg_clamp_min, cfg_clamp_max,
             in_valid, in_a, in_b, lane_acc, lane_done, res_ready,
      output cmd_ready, in_ready, lane_en, lane_op, lane_a, lane_b,
             lane_scale, lane_zero_pt, lane_clamp_min, lane_clamp_max,
             res_valid, res_data, busy, err, dbg_state
   );
endinterface

// File: rtl/boreal_vec_seq.sv
// Dot-product command sequencer: drives lanes through ZERO, MAC x len, optional SCALE
// and CLAMP, then captures the lane accumulators and offers them as one result.
module boreal_vec_seq #(
   parameter int NUM_LANES = 4,
   parameter int LEN_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   boreal_vec_seq_if.slave  bus
);
   localparam int AW = 8 * NUM_LANES;
   localparam int RW = 32 * NUM_LANES;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_MAC   = 3'd1;
   localparam logic [2:0] OP_SCALE = 3'd2;
   localparam logic [2:0] OP_CLAMP = 3'd3;
   localparam logic [2:0] OP_ZERO  = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ZERO  = 3'd1,
      S_MAC   = 3'd2,
      S_SCALE = 3'd3,
      S_CLAMP = 3'd4,
      S_DRAIN = 3'd5,
      S_OUT   = 3'd6
   } state_e;

   state_e            state_q, state_d;
   state_e            post_mac;
   logic [LEN_W:0]    cnt_q, cnt_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              do_scale_q, do_scale_d;
   logic              do_clamp_q, do_clamp_d;
   logic [15:0]       scale_q, scale_d;
   logic [15:0]       zero_pt_q, zero_pt_d;
   logic [31:0]       clamp_min_q, clamp_min_d;
   logic [31:0]       clamp_max_q, clamp_max_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              in_ready_q, in_ready_d;
   logic              lane_en_q, lane_en_d;
   logic [2:0]        lane_op_q, lane_op_d;
   logic [AW-1:0]     lane_a_q, lane_a_d;
   logic [AW-1:0]     lane_b_q, lane_b_d;
   logic              res_valid_q, res_valid_d;
   logic [RW-1:0]     res_data_q, res_data_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;

   logic              cmd_fire;
   logic              in_fire;
   logic              res_fire;

   assign cmd_fire = bus.cmd_valid & cmd_ready_q;
   assign in_fire  = bus.in_valid & in_ready_q;
   assign res_fire = res_valid_q & bus.res_ready;

   // Where the sequence continues once the MAC phase (possibly empty) is finished.
   always_comb begin
      if (do_scale_q) begin
         post_mac = S_SCALE;
      end else if (do_clamp_q) begin
         post_mac = S_CLAMP;
      end else begin
         post_mac = S_DRAIN;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      do_scale_d  = do_scale_q;
      do_clamp_d  = do_clamp_q;
      scale_d     = scale_q;
      zero_pt_d   = zero_pt_q;
      clamp_min_d = clamp_min_q;
      clamp_max_d = clamp_max_q;
      lane_en_d   = 1'b0;
      lane_op_d   = OP_NOP;
      lane_a_d    = lane_a_q;
      lane_b_d    = lane_b_q;
      res_data_d  = res_data_q;
      err_d       = err_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_fire) begin
               len_d       = bus.cmd_len;
               do_scale_d  = bus.cmd_do_scale;
               do_clamp_d  = bus.cmd_do_clamp;
               scale_d     = bus.cfg_scale;
               zero_pt_d   = bus.cfg_zero_pt;
               clamp_min_d = bus.cfg_clamp_min;
               clamp_max_d = bus.cfg_clamp_max;
               cnt_d       = '0;
               err_d       = 1'b0;
               state_d     = S_ZERO;
            end
         end
         S_ZERO: begin
            lane_en_d = 1'b1;
            lane_op_d = OP_ZERO;
            state_d   = (len_q == '0) ? post_mac : S_MAC;
         end
         S_MAC: begin
            // A cycle without an operand beat is a bubble: lanes see lane_en low.
            if (in_fire) begin
               lane_en_d = 1'b1;
               lane_op_d = OP_MAC;
               lane_a_d  = bus.in_a;
               lane_b_d  = bus.in_b;
               cnt_d     = cnt_q + 1'b1;
               if (cnt_d == {1'b0, len_q}) begin
                  state_d = post_mac;
               end
            end
         end
         S_SCALE: begin
            lane_en_d = 1'b1;
            lane_op_d = OP_SCALE;
            state_d   = do_clamp_q ? S_CLAMP : S_DRAIN;
         end
         S_CLAMP: begin
            lane_en_d = 1'b1;
            lane_op_d = OP_CLAMP;
            state_d   = S_DRAIN;
         end
         S_DRAIN: begin
            // First DRAIN cycle still carries the last op; sample once the lanes settled.
            if (!lane_en_q) begin
               if (bus.lane_done != {NUM_LANES{1'b1}}) begin
                  err_d = 1'b1;
               end
               res_data_d = bus.lane_acc;
               state_d    = S_OUT;
            end
         end
         S_OUT: begin
            if (res_fire) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      cmd_ready_d = (state_d == S_IDLE);
      in_ready_d  = (state_d == S_MAC);
      res_valid_d = (state_d == S_OUT);
      busy_d      = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         len_q       <= '0;
         do_scale_q  <= 1'b0;
         do_clamp_q  <= 1'b0;
         scale_q     <= '0;
         zero_pt_q   <= '0;
         clamp_min_q <= '0;
         clamp_max_q <= '0;
         cmd_ready_q <= 1'b0;
         in_ready_q  <= 1'b0;
         lane_en_q   <= 1'b0;
         lane_op_q   <= OP_NOP;
         lane_a_q    <= '0;
         lane_b_q    <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         do_scale_q  <= do_scale_d;
         do_clamp_q  <= do_clamp_d;
         scale_q     <= scale_d;
         zero_pt_q   <= zero_pt_d;
         clamp_min_q <= clamp_min_d;
         clamp_max_q <= clamp_max_d;
         cmd_ready_q <= cmd_ready_d;
         in_ready_q  <= in_ready_d;
         lane_en_q   <= lane_en_d;
         lane_op_q   <= lane_op_d;
         lane_a_q    <= lane_a_d;
         lane_b_q    <= lane_b_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

   assign bus.cmd_ready      = cmd_ready_q;
   assign bus.in_ready       = in_ready_q;
   assign bus.lane_en        = lane_en_q;
   assign bus.lane_op        = lane_op_q;
   assign bus.lane_a         = lane_a_q;
   assign bus.lane_b         = lane_b_q;
   assign bus.lane_scale     = scale_q;
   assign bus.lane_zero_pt   = zero_pt_q;
   assign bus.lane_clamp_min = clamp_min_q;
   assign bus.lane_clamp_max = clamp_max_q;
   assign bus.res_valid      = res_valid_q;
   assign bus.res_data       = res_data_q;
   assign bus.busy           = busy_q;
   assign bus.err            = err_q;
   assign bus.dbg_state      = state_q;
endmodule

// File: tb/tb_boreal_vec_seq.sv
// Bench for boreal_vec_seq: behavioural lane array, randomized dot-product commands
// and a reference computed directly from the operand lists.
module tb_boreal_vec_seq;
   localparam int NL = 4;
   localparam int LW = 16;
   localparam logic [2:0] OP_MAC = 3'd1, OP_SCALE = 3'd2, OP_CLAMP = 3'd3, OP_ZERO = 3'd5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   boreal_vec_seq_if #(.NUM_LANES(NL), .LEN_W(LW)) bus ();
   boreal_vec_seq #(.NUM_LANES(NL), .LEN_W(LW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Behavioural lane array: acts on whatever op the sequencer issues.
   int            acc_m [NL];
   logic [NL-1:0] done_r;
   logic          force_done_low = 1'b0;

   function automatic int lane_step(input int acc, input logic [2:0] op, input logic [7:0] a,
                                    input logic [7:0] b);
      int mn, mx;
      mn = int'($signed(bus.lane_clamp_min));
      mx = int'($signed(bus.lane_clamp_max));
      case (op)
         OP_ZERO:  return 0;
         OP_MAC:   return acc + int'($signed(a)) * int'($signed(b));
         OP_SCALE: return int'((longint'(acc) * longint'({16'h0, bus.lane_scale})) >>> 16)
                          + int'($signed(bus.lane_zero_pt));
         OP_CLAMP: return (acc < mn) ? mn : ((acc > mx) ? mx : acc);
         default:  return acc;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NL; i++) acc_m[i] <= 0;
         done_r <= '0;
      end else begin
         done_r <= {NL{bus.lane_en}};
         if (bus.lane_en) begin
            for (int i = 0; i < NL; i++)
               acc_m[i] <= lane_step(acc_m[i], bus.lane_op, bus.lane_a[8*i +: 8], bus.lane_b[8*i +: 8]);
         end
      end
   end

   for (genvar g = 0; g < NL; g++) begin : g_acc
      assign bus.lane_acc[32*g +: 32] = acc_m[g];
   end
   assign bus.lane_done = force_done_low ? '0 : done_r;

   // Monitor: lane ops seen and result latency.
   logic [2:0] got_q[$];
   logic [2:0] exp_q[$];
   int   last_en_cyc = 0;
   int   res_lat = 0;
   logic res_prev = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (bus.lane_en) begin
         got_q.push_back(bus.lane_op);
         last_en_cyc = cyc;
      end
      if (bus.res_valid && !res_prev) res_lat = cyc - last_en_cyc;
      res_prev = bus.res_valid;
   end

   logic [31:0] beat_a[$];
   logic [31:0] beat_b[$];

   task automatic gen_beats(input int len, input bit rnd, input logic [7:0] fa, input logic [7:0] fb);
      beat_a.delete();
      beat_b.delete();
      for (int i = 0; i < len; i++) begin
         beat_a.push_back(rnd ? $urandom : {NL{fa}});
         beat_b.push_back(rnd ? $urandom : {NL{fb}});
      end
   endtask

   task automatic run_cmd(input int len, input bit dsc, input bit dcl, input logic [15:0] sc,
                          input logic [15:0] zp, input int cmin, input int cmax,
                          input int gap_fix, input int hold, input bit ferr, input string name);
      int exp_res [NL];
      int guard, gaps, acc;
      logic [127:0] held;
      got_q.delete();
      exp_q.delete();
      exp_q.push_back(OP_ZERO);
      repeat (len) exp_q.push_back(OP_MAC);
      if (dsc) exp_q.push_back(OP_SCALE);
      if (dcl) exp_q.push_back(OP_CLAMP);
      for (int l = 0; l < NL; l++) begin
         acc = 0;
         for (int i = 0; i < len; i++)
            acc += int'($signed(beat_a[i][8*l +: 8])) * int'($signed(beat_b[i][8*l +: 8]));
         if (dsc) acc = int'((longint'(acc) * longint'({16'h0, sc})) >>> 16) + int'($signed(zp));
         if (dcl) acc = (acc < cmin) ? cmin : ((acc > cmax) ? cmax : acc);
         exp_res[l] = acc;
      end
      force_done_low = ferr;

      @(negedge clk);
      guard = 0;
      while (!bus.cmd_ready && guard < 50) begin @(negedge clk); guard++; end
      check({name, ":cmd_ready_idle"}, bus.cmd_ready, 1'b1);
      bus.cmd_valid = 1'b1;
      bus.cmd_len = LW'(len);
      bus.cmd_do_scale = dsc;
      bus.cmd_do_clamp = dcl;
      bus.cfg_scale = sc;
      bus.cfg_zero_pt = zp;
      bus.cfg_clamp_min = cmin;
      bus.cfg_clamp_max = cmax;
      @(negedge clk);
      check({name, ":cmd_ready_busy"}, bus.cmd_ready, 1'b0);
      check({name, ":busy"}, bus.busy, 1'b1);
      bus.cmd_valid = 1'b0;
      bus.cmd_len = LW'($urandom);
      bus.cmd_do_scale = 1'($urandom);
      bus.cmd_do_clamp = 1'($urandom);
      bus.cfg_scale = 16'($urandom);
      bus.cfg_zero_pt = 16'($urandom);
      bus.cfg_clamp_min = $urandom;
      bus.cfg_clamp_max = $urandom;

      for (int i = 0; i < len; i++) begin
         gaps = (gap_fix >= 0) ? gap_fix : (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
         repeat (gaps) begin bus.in_valid = 1'b0; @(negedge clk); end
         bus.in_valid = 1'b1;
         bus.in_a = beat_a[i];
         bus.in_b = beat_b[i];
         guard = 0;
         while (!bus.in_ready && guard < 50) begin @(negedge clk); guard++; end
         if (guard >= 50) check({name, ":in_ready_timeout"}, 1'b0, 1'b1);
         @(negedge clk);
      end
      // Junk beat offered after the last one must never be taken.
      bus.in_valid = 1'b1;
      bus.in_a = $urandom;
      bus.in_b = $urandom;

      guard = 0;
      while (!bus.res_valid && guard < 100) begin @(negedge clk); guard++; end
      check({name, ":res_valid_timeout"}, bus.res_valid, 1'b1);
      #1;
      check({name, ":res_latency"}, 128'(res_lat), 128'(2));
      check({name, ":op_count"}, 128'(got_q.size()), 128'(exp_q.size()));
      while (exp_q.size() > 0 && got_q.size() > 0)
         check({name, ":op"}, got_q.pop_front(), exp_q.pop_front());
      for (int l = 0; l < NL; l++)
         check({name, ":res_lane"}, bus.res_data[32*l +: 32], $unsigned(exp_res[l]));
      check({name, ":err"}, bus.err, ferr);

      held = bus.res_data;
      repeat (hold) @(negedge clk);
      check({name, ":res_stable"}, bus.res_data, held);
      check({name, ":res_held"}, bus.res_valid, 1'b1);
      check({name, ":cmd_ready_out"}, bus.cmd_ready, 1'b0);
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      bus.in_valid = 1'b0;
      check({name, ":res_drop"}, bus.res_valid, 1'b0);
      check({name, ":busy_drop"}, bus.busy, 1'b0);
      force_done_low = 1'b0;
   endtask

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      int len, cmin, cmax;
      bus.cmd_valid = 1'b0; bus.cmd_len = '0; bus.cmd_do_scale = 1'b0; bus.cmd_do_clamp = 1'b0;
      bus.cfg_scale = '0; bus.cfg_zero_pt = '0; bus.cfg_clamp_min = '0; bus.cfg_clamp_max = '0;
      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.res_ready = 1'b0;

      repeat (3) @(negedge clk);
      check("rst:cmd_ready", bus.cmd_ready, 1'b0);
      check("rst:in_ready", bus.in_ready, 1'b0);
      check("rst:lane_en", bus.lane_en, 1'b0);
      check("rst:lane_op", bus.lane_op, 3'd0);
      check("rst:res_valid", bus.res_valid, 1'b0);
      check("rst:res_data", bus.res_data, 128'd0);
      check("rst:busy", bus.busy, 1'b0);
      check("rst:err", bus.err, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("rst:cmd_ready_after", bus.cmd_ready, 1'b1);

      // Abort a command in the middle of its MAC phase.
      bus.cmd_valid = 1'b1; bus.cmd_len = 16'd10;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.in_valid = 1'b1; bus.in_a = $urandom; bus.in_b = $urandom;
      repeat (4) @(negedge clk);
      check("abort:in_mac", bus.in_ready, 1'b1);
      rst_n = 1'b0;
      #1;
      check("abort:lane_en", bus.lane_en, 1'b0);
      check("abort:res_valid", bus.res_valid, 1'b0);
      check("abort:busy", bus.busy, 1'b0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("abort:cmd_ready", bus.cmd_ready, 1'b1);
      check("abort:no_result", bus.res_valid, 1'b0);
      check("abort:idle_lane_en", bus.lane_en, 1'b0);

      gen_beats(3, 1'b0, 8'd2, 8'd3);
      run_cmd(3, 1'b0, 1'b0, 16'h0, 16'h0, 0, 0, 0, 0, 1'b0, "len3");
      gen_beats(2, 1'b1, 8'd0, 8'd0);
      run_cmd(2, 1'b0, 1'b0, 16'h0, 16'h0, 0, 0, 2, 0, 1'b0, "gaps");
      gen_beats(1, 1'b0, 8'h80, 8'h80);
      run_cmd(1, 1'b1, 1'b0, 16'h8000, 16'd5, 0, 1000, 0, 0, 1'b0, "scale");
      run_cmd(1, 1'b1, 1'b1, 16'h8000, 16'd5, 0, 1000, 0, 0, 1'b0, "scale_clamp");
      gen_beats(0, 1'b0, 8'd0, 8'd0);
      run_cmd(0, 1'b0, 1'b1, 16'h0, 16'h0, 10, 20, 0, 0, 1'b0, "len0_clamp");
      gen_beats(4, 1'b1, 8'd0, 8'd0);
      run_cmd(4, 1'b0, 1'b0, 16'h0, 16'h0, 0, 0, -1, 5, 1'b1, "hold_err");
      gen_beats(2, 1'b1, 8'd0, 8'd0);
      run_cmd(2, 1'b1, 1'b0, 16'h4000, 16'hFFF0, 0, 0, -1, 1, 1'b0, "err_clear");
      gen_beats(300, 1'b1, 8'd0, 8'd0);
      run_cmd(300, 1'b0, 1'b0, 16'h0, 16'h0, 0, 0, 0, 0, 1'b0, "long");

      for (int t = 0; t < 20; t++) begin
         len = $urandom_range(0, 12);
         cmin = -int'($urandom_range(0, 5000));
         cmax = int'($urandom_range(0, 5000));
         gen_beats(len, 1'b1, 8'd0, 8'd0);
         run_cmd(len, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), cmin, cmax,
                 -1, $urandom_range(0, 3), 1'b0, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
